// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Serial pattern detector with a runtime-loadable PAT_W-bit pattern and a
//   windowed hit counter. Bits are shifted in MSB-first whenever i_bit_valid
//   is high. Detection is either overlapping or non-overlapping. Hits are
//   accumulated over a free-running window of WINDOW_CYCLES clocks, and the
//   count is published once per window.
//
//   Optional build macro PAT_MASK_EN adds a per-bit don't-care mask. When the
//   macro is defined, mask bit 0 means that pattern bit is ignored.
//
// Ports
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_bit_valid      qualifies i_bit_seq
//   i_bit_seq        serial data bit, first bit is the pattern MSB
//   i_overlap_en     1 = overlapping detection, 0 = restart after each hit
//   i_pat_load       one-cycle strobe that loads i_pat_data (and i_pat_mask)
//   i_pat_data       new pattern value
//   i_pat_mask       new don't-care mask (PAT_MASK_EN only)
//   o_seq_detected   registered one-cycle hit pulse
//   o_hit_count      hit count of the last completed window
//   o_hit_valid      one-cycle pulse when o_hit_count / o_hit_ovf update
//   o_hit_ovf        last completed window saturated its counter
//   o_pattern        active pattern
//   o_pat_mask       active mask (PAT_MASK_EN only)
module seq_pattern_detector #(
    parameter int               PAT_W         = 9,
    parameter logic [PAT_W-1:0] PAT_RST       = 9'b0_1100_1011,
    parameter int               WINDOW_CYCLES = 1000,
    parameter int               CNT_W         = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit_valid,
    input  logic             i_bit_seq,
    input  logic             i_overlap_en,
    input  logic             i_pat_load,
    input  logic [PAT_W-1:0] i_pat_data,
`ifdef PAT_MASK_EN
    input  logic [PAT_W-1:0] i_pat_mask,
    output logic [PAT_W-1:0] o_pat_mask,
`endif
    output logic             o_seq_detected,
    output logic [CNT_W-1:0] o_hit_count,
    output logic             o_hit_valid,
    output logic             o_hit_ovf,
    output logic [PAT_W-1:0] o_pattern
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              det_q, det_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;
`ifdef PAT_MASK_EN
    logic [PAT_W-1:0]  mask_q, mask_d;
`endif

    logic [PAT_W-1:0]  cand;      // history plus the incoming bit
    logic [PAT_W-1:0]  hit_bits;  // 1 where a bit matches or is don't-care
    logic              match;
    logic              match_eff; // a load in the same cycle discards the bit
    logic              acc_max;
    logic              win_last;
    logic [CNT_W-1:0]  acc_inc;

    always_comb begin
        cand      = {hist_q, i_bit_seq};
`ifdef PAT_MASK_EN
        hit_bits  = (cand ~^ pat_q) | ~mask_q;
`else
        hit_bits  = cand ~^ pat_q;
`endif
        match     = i_bit_valid && (fill_q == FILL_MAX) && (&hit_bits);
        match_eff = match && !i_pat_load;
        acc_max   = &acc_q;
        win_last  = (win_q == WIN_LAST);
        acc_inc   = acc_max ? acc_q : acc_q + CNT_W'(1);

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        acc_d  = acc_q;
        sat_d  = sat_q;
        win_d  = win_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;
        det_d  = match_eff;
`ifdef PAT_MASK_EN
        mask_d = mask_q;
`endif

        if (i_pat_load) begin
            pat_d  = i_pat_data;
`ifdef PAT_MASK_EN
            mask_d = i_pat_mask;
`endif
            hist_d = '0;
            fill_d = '0;
        end else if (i_bit_valid) begin
            hist_d = cand[PAT_W-2:0];
            if (match && !i_overlap_en)
                fill_d = '0;                 // next hit needs PAT_W fresh bits
            else if (fill_q != FILL_MAX)
                fill_d = fill_q + FILL_W'(1);
        end

        if (win_last) begin
            // Boundary: publish, including a hit that completes this cycle.
            win_d = '0;
            cnt_d = match_eff ? acc_inc : acc_q;
            ovf_d = sat_q | (match_eff & acc_max);
            vld_d = 1'b1;
            acc_d = '0;
            sat_d = 1'b0;
        end else begin
            win_d = win_q + WIN_W'(1);
            if (i_pat_load) begin
                acc_d = '0;
                sat_d = 1'b0;
            end else if (match) begin
                acc_d = acc_inc;
                if (acc_max) sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_RST;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            win_q  <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef PAT_MASK_EN
            mask_q <= '1;
`endif
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            acc_q  <= acc_d;
            sat_q  <= sat_d;
            win_q  <= win_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
`ifdef PAT_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end

    assign o_seq_detected = det_q;
    assign o_hit_count    = cnt_q;
    assign o_hit_valid    = vld_q;
    assign o_hit_ovf      = ovf_q;
    assign o_pattern      = pat_q;
`ifdef PAT_MASK_EN
    assign o_pat_mask     = mask_q;
`endif

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial pattern detector and windowed hit counter, successor to the fixed 9-bit birthday-pattern receiver. Monitors a qualified serial bit stream for a runtime-loadable PAT_W-bit pattern, with selectable overlapping or non-overlapping detection. Counts hits over an internally timed window and publishes the count once per window. Sits after the serial transmitter/bit source and feeds the display path.

Parameters:
PAT_W, 9, pattern length in bits (2..32)
PAT_RST, 9'b0_1100_1011, pattern value after reset (PAT_W bits)
WINDOW_CYCLES, 1000, clock cycles per reporting window (>=2)
CNT_W, 6, width of hit counter and published count

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_bit_valid  input  1  i_bit_seq is sampled only when 1
i_bit_seq  input  1  serial data bit; first bit received is the pattern MSB
i_overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
i_pat_load  input  1  one-cycle strobe: load new pattern
i_pat_data  input  PAT_W  new pattern value, sampled when i_pat_load=1
o_seq_detected  output  1  one-cycle registered hit pulse
o_hit_count  output  CNT_W  hit count of the last completed window
o_hit_valid  output  1  one-cycle pulse: o_hit_count updated
o_hit_ovf  output  1  the last completed window saturated its counter
o_pattern  output  PAT_W  currently active pattern

Behaviour:
- Reset (i_rst=1 at clock edge): history=0, fill=0, pattern=PAT_RST, accumulator=0, window counter=0. Outputs o_seq_detected=0, o_hit_count=0, o_hit_valid=0, o_hit_ovf=0, o_pattern=PAT_RST. Reset overrides all other inputs, including mid-window and mid-pattern.
- History: PAT_W-1 bit shift register holding the most recent bits. Fill counter runs 0..PAT_W-1 and saturates.
- Match (combinational): i_bit_valid=1, fill==PAT_W-1, and {history, i_bit_seq}==pattern. A match cannot occur until PAT_W valid bits have arrived since reset, load, or a non-overlap restart.
- Any cycle with i_bit_valid=1: history shifts left with i_bit_seq entering the LSB, and fill increments. On a match with i_overlap_en=0, fill is cleared to 0 instead, so the next hit needs PAT_W fresh bits. With i_overlap_en=1, fill is held.
- i_bit_valid=0: history and fill are held. Gaps are transparent.
- o_seq_detected: registered match, latency 1 cycle after the completing bit. Back-to-back pulses are possible in overlap mode when the pattern permits.
- Pattern load: when i_pat_load=1, pattern<=i_pat_data, and history, fill and accumulator are cleared. o_seq_detected is 0 the next cycle. A load has priority over a bit in the same cycle, and that bit is discarded. The window counter is not affected.
- Window: the counter runs 0..WINDOW_CYCLES-1 and wraps, free-running. On the cycle where counter==WINDOW_CYCLES-1:
  - at the next edge, o_hit_count<=accumulator plus a match that cycle (saturated);
  - o_hit_ovf<=the saturation flag, including that cycle's saturation;
  - o_hit_valid=1 for exactly one cycle;
  - the accumulator and saturation flag clear to 0. A match in the boundary cycle counts in the closing window only.
- Accumulator: increments by 1 on each match and saturates at 2^CNT_W-1. An increment attempted while at the maximum sets the saturation flag.
- Load during the boundary cycle: the published values are the pre-load accumulator, and the new window starts at 0.
- o_hit_count and o_hit_ovf hold their values between o_hit_valid pulses.

Optional Feature:
PAT_MASK_EN
- Defined: adds input i_pat_mask [PAT_W], loaded alongside i_pat_data on i_pat_load, with reset value all ones. Match requires ((history,bit) XNOR pattern) OR ~mask to be all ones, so mask bit 0 means don't-care. Adds output o_pat_mask [PAT_W].
- Undefined: ports absent; exact match on all PAT_W bits.

Test Plan:
- Defaults, overlap_en=0, pattern 9'b011001011 streamed once with bit_valid always 1 -> o_seq_detected=1 exactly 1 cycle after the 9th bit. At the cycle-999 boundary: o_hit_count=1, o_hit_valid pulse, o_hit_ovf=0.
- Load pattern 9'b101010101, then stream 11 bits 10101010101: overlap_en=1 -> 2 hits; overlap_en=0 -> 1 hit.
- Same stream with i_bit_valid low for 3 cycles between every bit -> identical hit count; detection pulse 1 cycle after the last valid bit.
- Short window (WINDOW_CYCLES=100, CNT_W=3), overlap pattern 9'b111111111 with continuous ones -> o_hit_count=7, o_hit_ovf=1. Next window with no bits -> o_hit_count=0, o_hit_ovf=0.
- Pattern completes in the boundary cycle -> counted in the closing window; the next window's report excludes it. i_pat_load coincident with a completing bit -> no pulse, accumulator 0.
- Assert i_rst for 1 cycle after 8 of 9 pattern bits, then send the 9th bit -> no detection. All outputs at reset values the cycle after reset.
